// File: rtl/wb_timer_sched.sv
// -----------------------------------------------------------------------------
// wb_timer_sched
//
// Wishbone-slave timer scheduler. NUM_CH software deadlines share one
// free-running 32-bit counter and one comparator. A scan pointer visits one
// channel per cycle while the timer runs. The visited channel's deadline is
// compared against the counter with a wrap-safe compare (MSB of time - cmp).
// A hit latches the channel's pending bit. The level interrupt is the
// registered OR of pending & enable.
//
// Register map (word offsets, addr[7:2] decoded):
//   0x00        CTRL     bit0 RUN (rw), bit1 CLR (write 1 zeroes counter, reads 0)
//   0x04        TIME     counter, rw
//   0x08        PENDING  r: pending bits, w: write-1-to-clear
//   0x0C        ENABLE   per-channel interrupt enable, rw
//   0x10+4k     CMP[k]   deadline, rw; a write arms channel k and clears pending[k]
//   0x40+4k     PERIOD[k] auto-reload period (only with TIMER_SCHED_PERIODIC_EN)
//   other       reads 0, writes ignored, still acknowledged
//
// Build option:
//   TIMER_SCHED_PERIODIC_EN - when defined, adds the PERIOD[k] registers.
//   A hit on a channel with a nonzero period advances CMP[k] by PERIOD[k] and
//   keeps the channel armed. When undefined, every channel is one-shot.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   wb_addr_i    byte address; bits [7:2] select the register
//   wb_data_i    write data
//   wb_we_i      write enable
//   wb_sel_i     byte selects; writes apply only when all are set
//   wb_stb_i     strobe
//   wb_cyc_i     cycle
//   wb_ack_o     acknowledge, one cycle, the cycle after the request
//   wb_data_o    read data, valid with ack
//   timer_irq_o  level interrupt, registered
// -----------------------------------------------------------------------------
module wb_timer_sched #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4,
    parameter int NUM_CH        = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     timer_irq_o
);

    localparam int DW    = WB_DATA_WIDTH;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [5:0] IDX_CTRL = 6'h00;
    localparam logic [5:0] IDX_TIME = 6'h01;
    localparam logic [5:0] IDX_PEND = 6'h02;
    localparam logic [5:0] IDX_EN   = 6'h03;
    localparam logic [5:0] IDX_CMP0 = 6'h04;
`ifdef TIMER_SCHED_PERIODIC_EN
    localparam logic [5:0] IDX_PER0 = 6'h10;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              ack_q;
    logic [DW-1:0]     rdata_q;
    logic              irq_q;
    logic              run_q;
    logic [DW-1:0]     time_q;
    logic [DW-1:0]     cmp_q [NUM_CH];
    logic [NUM_CH-1:0] armed_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] enable_q;
    logic [PTR_W-1:0]  ptr_q;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic [DW-1:0]     period_q [NUM_CH];
`endif

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic [5:0]        widx;
    logic              req;
    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_time;
    logic              wr_pend;
    logic              wr_enable;
    logic [NUM_CH-1:0] wr_cmp;
    logic [NUM_CH-1:0] wr_per;
    logic [DW-1:0]     rd_mux;

    assign widx  = wb_addr_i[7:2];
    // Gating with ack_q makes a held strobe see an ack every second cycle.
    assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
    // Partial-select writes are acknowledged but dropped.
    assign wr_en = req & wb_we_i & (&wb_sel_i);

    always_comb begin
        wr_ctrl   = wr_en && (widx == IDX_CTRL);
        wr_time   = wr_en && (widx == IDX_TIME);
        wr_pend   = wr_en && (widx == IDX_PEND);
        wr_enable = wr_en && (widx == IDX_EN);
        wr_cmp    = '0;
        wr_per    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_cmp[k] = wr_en && (widx == IDX_CMP0 + 6'(k));
`ifdef TIMER_SCHED_PERIODIC_EN
            wr_per[k] = wr_en && (widx == IDX_PER0 + 6'(k));
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        case (widx)
            IDX_CTRL: rd_mux[0]          = run_q;
            IDX_TIME: rd_mux             = time_q;
            IDX_PEND: rd_mux[NUM_CH-1:0] = pending_q;
            IDX_EN:   rd_mux[NUM_CH-1:0] = enable_q;
            default:  rd_mux             = '0;
        endcase
        // CMP and PERIOD windows never overlap the fixed registers for NUM_CH <= 8.
        for (int k = 0; k < NUM_CH; k++) begin
            if (widx == IDX_CMP0 + 6'(k)) begin
                rd_mux = cmp_q[k];
            end
`ifdef TIMER_SCHED_PERIODIC_EN
            if (widx == IDX_PER0 + 6'(k)) begin
                rd_mux = period_q[k];
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Scanner: evaluate the channel under the pointer
    // -------------------------------------------------------------------------
    logic [DW-1:0]     cur_cmp;
    logic [DW-1:0]     cur_diff;
    logic              cur_armed;
    logic              hit;
    logic [NUM_CH-1:0] hit_vec;
    logic [NUM_CH-1:0] reload_vec;

    always_comb begin
        cur_cmp   = '0;
        cur_armed = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                cur_cmp   = cmp_q[k];
                cur_armed = armed_q[k];
            end
        end
        // Deadline reached when time is at or past cmp within half the range;
        // this stays correct across counter wrap.
        cur_diff = time_q - cur_cmp;
        hit      = run_q & cur_armed & ~cur_diff[DW-1];
        hit_vec  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit_vec[k] = hit && (ptr_q == PTR_W'(k));
        end
    end

`ifdef TIMER_SCHED_PERIODIC_EN
    always_comb begin
        reload_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            reload_vec[k] = hit_vec[k] && (period_q[k] != '0);
        end
    end
`else
    assign reload_vec = '0;
`endif

    // -------------------------------------------------------------------------
    // Pending / armed next state
    //   w1c is applied first so a same-cycle hit re-sets the bit; a CMP write
    //   is applied last so it overrides a same-cycle hit.
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] armed_nxt;

    always_comb begin
        pending_nxt = pending_q;
        if (wr_pend) begin
            pending_nxt = pending_nxt & ~wb_data_i[NUM_CH-1:0];
        end
        pending_nxt = (pending_nxt | hit_vec) & ~wr_cmp;
        armed_nxt   = (armed_q & ~(hit_vec & ~reload_vec)) | wr_cmp;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            run_q     <= 1'b0;
            time_q    <= '0;
            armed_q   <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            ptr_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cmp_q[k] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
                period_q[k] <= '0;
`endif
            end
        end else begin
            ack_q   <= req;
            rdata_q <= (req && !wb_we_i) ? rd_mux : '0;
            irq_q   <= |(pending_q & enable_q);

            if (wr_ctrl) begin
                run_q <= wb_data_i[0];
            end

            if (wr_time) begin
                time_q <= wb_data_i;
            end else if (wr_ctrl && wb_data_i[1]) begin
                time_q <= '0;
            end else if (run_q) begin
                time_q <= time_q + DW'(1);
            end

            if (run_q) begin
                ptr_q <= (ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
            end

            if (wr_enable) begin
                enable_q <= wb_data_i[NUM_CH-1:0];
            end

            pending_q <= pending_nxt;
            armed_q   <= armed_nxt;

            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_cmp[k]) begin
                    cmp_q[k] <= wb_data_i;
                end
`ifdef TIMER_SCHED_PERIODIC_EN
                else if (reload_vec[k]) begin
                    cmp_q[k] <= cmp_q[k] + period_q[k];
                end
                if (wr_per[k]) begin
                    period_q[k] <= wb_data_i;
                end
`endif
            end
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_data_o   = rdata_q;
    assign timer_irq_o = irq_q;

    // Address bits outside the register window are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{wb_addr_i[WB_ADDR_WIDTH-1:8], wb_addr_i[1:0], wr_per};

endmodule
